pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register replacing the fixed per-stage registers (IF/ID through MEM/WB) with one reusable block. Carries a control field and a data field between stages under a valid/ready handshake, supports stall via back-pressure and synchronous flush, and gates control bits on bubbles so a killed stage never writes state. An optional skid buffer registers `ready_o` to break the combinational back-pressure path. A saturating counter reports output-stall cycles.

## Interface
- `DATA_W`, 64: width of the data field (results, memory data, register index packed by the instantiator).
- `CTRL_W`, 2: width of the control field (e.g. memtoreg, regwrite); forced to zero whenever the output is not valid.
- `CNT_W`, 16: width of the stall counter.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  synchronous kill of all held entries.
- `valid_i`  in  1  upstream entry valid.
- `ready_o`  out  1  block can accept an entry this cycle.
- `ctrl_i`  in  CTRL_W  upstream control field.
- `data_i`  in  DATA_W  upstream data field.
- `valid_o`  out  1  downstream entry valid.
- `ready_i`  in  1  downstream accepts this cycle.
- `ctrl_o`  out  CTRL_W  control field; `valid_o ? ctrl_q : 0`.
- `data_o`  out  DATA_W  data field; holds last loaded value when invalid.
- `stall_cnt_o`  out  CNT_W  cycles with `valid_o & ~ready_i`.

## Operation
- Transfer in: `valid_i & ready_o`. Transfer out: `valid_o & ready_i`.
- Priority per cycle: `rst_i` > `flush_i` > handshake.
- Reset: `valid_o`=0, `ctrl_o`=0, `data_o`=0, `stall_cnt_o`=0, skid entry empty; `ready_o`=1 from the first cycle after reset deassertion. Handshakes during `rst_i` are ignored.
- Flush: all valid bits cleared (main and skid), state EMPTY; an input offered in the flush cycle is dropped; data registers hold (don't care). Counter not cleared.
- Without skid (see Configuration): single register; `ready_o = ~valid_o | ready_i` (combinational); on transfer in, load `ctrl_i`/`data_i`, set valid; on transfer out without transfer in, clear valid.
- With skid: states EMPTY, FULL (main only), SKID (main + skid); `ready_o` = registered `state != SKID`.
  - EMPTY: `valid_i` -> FULL, load main.
  - FULL: `valid_i & ready_i` -> FULL, main <= input; `~valid_i & ready_i` -> EMPTY; `valid_i & ~ready_i` -> SKID, skid <= input; else hold.
  - SKID: `ready_i` -> FULL, main <= skid; else hold. Input ignored (`ready_o`=0).
- Ordering strictly FIFO; no entry duplicated or lost except by flush.
- Counter: +1 each cycle with `valid_o & ~ready_i` and not in reset; saturates at 2^CNT_W-1, never wraps.

## Timing
- Latency: 1 cycle, input transfer at edge N -> `valid_o` at N+1.
- Throughput: 1 entry/cycle in both modes when `ready_i` stays high.
- With skid: `ready_o` has no combinational path from `ready_i`; falls one cycle after the stall begins; at most one extra entry absorbed.
- Without skid: `ready_o` combinational from `ready_i` and `valid_o`.
- `ctrl_o` gating combinational from `valid_o` only (register-to-output).

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid implementation, registered `ready_o`, state machine above.
- Not defined: single-entry register, combinational `ready_o`; no skid storage is synthesised. Port list identical in both builds.

## Structure
- Package `pipe_pkg`: state typedef (`PIPE_EMPTY`, `PIPE_FULL`, `PIPE_SKID`), default width constants for `DATA_W`/`CTRL_W`/`CNT_W`.
- Sub-module `sat_counter` (parameter `W`, inputs `clk_i`, `rst_i`, `inc_i`, output `cnt_o`) for the stall counter.

## Test plan
- Reset then stream `data_i`=1..8, `ready_i`=1 -> `data_o`=1..8 on consecutive cycles, one cycle late; `stall_cnt_o`=0.
- Skid build: load A, B; drop `ready_i` while offering B -> `ready_o`=0 next cycle, `data_o`=A held; raise `ready_i` -> A, B out in order, nothing lost.
- Flush in SKID state with `valid_i`=1, `ctrl_i`=2'b11 -> next cycle `valid_o`=0, `ctrl_o`=0, `ready_o`=1; offered entry never appears.
- `CNT_W`=4, hold `valid_o`=1, `ready_i`=0 for 20 cycles -> `stall_cnt_o` reaches 15 and stays 15.
- Assert `rst_i` mid-stream with entries held -> next cycle all outputs zero, counter zero, `ready_o`=1.
- Non-skid build: `valid_o`=1, `ready_i`=0 -> `ready_o`=0 same cycle; `ready_i`=1 -> `ready_o`=1 same cycle, back-to-back transfer.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for pipe_stage_reg.
//   pipe_state_t  occupancy of the stage in the skid build
//                 (EMPTY / FULL = main only / SKID = main + skid)
//   *_W_DEF       default widths for the DATA_W, CTRL_W and CNT_W parameters
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W_DEF = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that saturates at all-ones and never wraps.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset, clears the count
//   inc_i  count this cycle
//   cnt_o  current count (registered)
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline stage register with valid/ready handshake,
// synchronous flush, control-bit gating on bubbles and a saturating
// output-stall counter.
//
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid version with a
// registered ready_o; otherwise a single register with combinational ready_o.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             kill every held entry (input offered this cycle dropped)
//   valid_i/ready_o     upstream handshake
//   ctrl_i, data_i      upstream control / data fields
//   valid_o/ready_i     downstream handshake
//   ctrl_o              control field, forced to zero while valid_o is low
//   data_o              data field, holds last loaded value when invalid
//   stall_cnt_o         saturating count of cycles with valid_o & ~ready_i
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_t       state, state_nx;
  logic              ready_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              load_main, main_from_skid, load_skid;

  // ready_q is computed from the next state so it always equals
  // (state != PIPE_SKID) without any path from ready_i to ready_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= PIPE_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != PIPE_SKID);
    end
  end

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_nx = PIPE_EMPTY;
    end else begin
      unique case (state)
        PIPE_EMPTY: begin
          if (valid_i) begin
            state_nx  = PIPE_FULL;
            load_main = 1'b1;
          end
        end
        PIPE_FULL: begin
          if (ready_i) begin
            if (valid_i) load_main = 1'b1;
            else         state_nx  = PIPE_EMPTY;
          end else if (valid_i) begin
            state_nx  = PIPE_SKID;
            load_skid = 1'b1;
          end
        end
        PIPE_SKID: begin
          if (ready_i) begin
            state_nx       = PIPE_FULL;
            main_from_skid = 1'b1;
          end
        end
        default: state_nx = PIPE_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q      <= '0;
      data_q      <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (load_main) begin
        ctrl_q <= ctrl_i;
        data_q <= data_i;
      end else if (main_from_skid) begin
        ctrl_q <= skid_ctrl_q;
        data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= ctrl_i;
        skid_data_q <= data_i;
      end
    end
  end

  always_comb begin
    valid_o = (state != PIPE_EMPTY);
    ready_o = ready_q;
  end

`else

  logic valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (valid_i && ready_o) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  always_comb begin
    valid_o = valid_q;
    ready_o = ~valid_q | ready_i;
  end

`endif

  always_comb begin
    ctrl_o = valid_o ? ctrl_q : '0;
    data_o = data_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (valid_o & ~ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg. The reference model
// is the set of entries accepted but not yet delivered (a queue); its size
// against the stage capacity predicts valid_o / ready_o, its head predicts the
// output fields, and a saturating integer predicts the stall counter.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;
  localparam int unsigned NW = 4;
  localparam int unsigned CNT_MAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o, valid_o;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [NW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        sb[$];
  int unsigned cnt_model = 0;
  bit          exp_ready = 1'b1;
  bit          exp_valid = 1'b0;
  bit          mon_en = 1'b0;
  int unsigned total = 0;
  int unsigned passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Monitor: compares the DUT against the model just before each rising edge
  // and retires the head entry on an output transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_valid = (sb.size() != 0);
      exp_ready = SKID ? (sb.size() < 2) : (!exp_valid || ready_i);
      check("valid_o", 64'(valid_o), 64'(exp_valid));
      check("ready_o", 64'(ready_o), 64'(exp_ready));
      check("stall_cnt_o", 64'(stall_cnt_o), 64'(cnt_model));
      if (exp_valid) begin
        check("data_o", 64'(data_o), 64'(sb[0].d));
        check("ctrl_o", 64'(ctrl_o), 64'(sb[0].c));
        if (ready_i) void'(sb.pop_front());
      end else begin
        check("ctrl_o_bubble", 64'(ctrl_o), 64'd0);
      end
      if (rst_i) cnt_model = 0;
      else if (exp_valid && !ready_i && cnt_model < CNT_MAX) cnt_model++;
    end
  end

  // One clock cycle of stimulus; the accepted entry (if any) is pushed into
  // the scoreboard after the monitor has seen this cycle.
  task automatic step(input bit r, input bit f, input bit v, input logic [CW-1:0] c,
                      input logic [DW-1:0] d, input bit rdy);
    rst_i   = r;
    flush_i = f;
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = rdy;
    @(negedge clk);
    #1;
    if (r || f) sb.delete();
    else if (v && exp_ready) sb.push_back('{c: c, d: d});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, 64'(valid_o), 64'd0);
    check({tag, "_ctrl_o"}, 64'(ctrl_o), 64'd0);
    check({tag, "_data_o"}, 64'(data_o), 64'd0);
    check({tag, "_stall_cnt_o"}, 64'(stall_cnt_o), 64'd0);
    check({tag, "_ready_o"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1, 0, 0, '0, '0, 0);
    step(1, 0, 1, 2'b11, 32'hdead, 1);
    step(0, 0, 0, '0, '0, 0);
    check_reset_outputs("reset");

    // Stream 1..8 with the downstream always ready.
    for (int i = 1; i <= 8; i++) step(0, 0, 1, CW'($urandom), DW'(i), 1);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 0, '0, '0, 1);
    check("stream_stall_cnt", 64'(stall_cnt_o), 64'd0);

    // Load A, then offer B while the downstream stalls, then release.
    step(0, 0, 1, 2'b01, 32'haaaa_0001, 1);
    step(0, 0, 1, 2'b10, 32'hbbbb_0002, 0);
    step(0, 0, 1, 2'b10, 32'hbbbb_0002, 0);
    step(0, 0, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 0, '0, '0, 1);

    // Fill to capacity, then flush while offering a ctrl=11 entry.
    step(0, 0, 1, 2'b01, 32'h1111, 0);
    step(0, 0, 1, 2'b10, 32'h2222, 0);
    step(0, 0, 1, 2'b11, 32'h3333, 0);
    step(0, 1, 1, 2'b11, 32'h4444, 0);
    check("flush_valid_o", 64'(valid_o), 64'd0);
    check("flush_ctrl_o", 64'(ctrl_o), 64'd0);
    check("flush_ready_o", 64'(ready_o), 64'd1);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 0, '0, '0, 1);

    // Hold a stalled entry for 20 cycles: the counter saturates.
    step(0, 0, 1, 2'b01, 32'h5555, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, '0, 0);
    check("sat_stall_cnt", 64'(stall_cnt_o), 64'(CNT_MAX));
    step(0, 0, 0, '0, '0, 0);
    check("sat_stall_cnt_hold", 64'(stall_cnt_o), 64'(CNT_MAX));

    // Mid-stream reset with entries held.
    step(0, 0, 1, 2'b10, 32'h6666, 0);
    step(1, 0, 1, 2'b11, 32'h7777, 0);
    check_reset_outputs("midreset");

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0, CW'($urandom), DW'($urandom),
           $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 1);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
